// File: rtl/rm_violation_logger_pkg.sv
// rtl/rm_violation_logger_pkg.sv - shared widths and record type for the violation logger
//
// Purpose: index widths, pc width and the queued record layout used by
//          rm_violation_logger and its record FIFO.
// Contents: RM_VLEN, RM_NUM_LANES, RM_NUM_RULES, RM_LANE_IDX_W, RM_RULE_IDX_W,
//           rm_idx_w(), rm_viol_rec_t.
// Optional: RM_VIOL_TIMESTAMP_EN adds a 32-bit ts field to rm_viol_rec_t.

package rm_violation_logger_pkg;

    // Width of the committing pc.
    localparam int unsigned RM_VLEN      = 64;
    localparam int unsigned RM_NUM_LANES = 4;
    localparam int unsigned RM_NUM_RULES = 5;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int unsigned rm_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned RM_LANE_IDX_W = rm_idx_w(RM_NUM_LANES);
    localparam int unsigned RM_RULE_IDX_W = rm_idx_w(RM_NUM_RULES);

    typedef struct packed {
`ifdef RM_VIOL_TIMESTAMP_EN
        logic [31:0]              ts;
`endif
        logic [RM_LANE_IDX_W-1:0] lane;
        logic [RM_RULE_IDX_W-1:0] rule;
        logic [RM_VLEN-1:0]       pc;
    } rm_viol_rec_t;

endpackage

// File: rtl/rm_viol_fifo.sv
// rtl/rm_viol_fifo.sv - generic synchronous FIFO with registered head
//
// Purpose: circular-buffer FIFO of any type T, DEPTH entries (power of 2, >= 2).
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i, data_i write request and data; ignored when full unless popping
//   pop_i          read request; ignored when empty
//   data_o         head entry (don't-care when empty)
//   full_o/empty_o occupancy flags

module rm_viol_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed when non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rm_violation_logger.sv
// rtl/rm_violation_logger.sv - turns rising rule-violation flags into queued records
//
// Purpose: edge-detects per-lane/per-rule violation flags, keeps one pending bit
//          per flag, grants one record per cycle round-robin across lanes and
//          queues {lane, rule, pc[, ts]} records; sticky irq and saturating
//          lost-event counter.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   monitor_i          [lane][rule] violation flags, lane-major
//   lane_reset_i       per-lane re-arm (clears pending and edge history)
//   pc_i               pc captured when a lane first becomes pending
//   rec_valid_o/rec_o  FIFO head; popped on rec_valid_o & rec_ready_i
//   irq_o, clear_i     sticky "records queued" flag and its clear
//   overflow_cnt_o     count of rises lost on an already-pending bit
// Optional: RM_VIOL_TIMESTAMP_EN adds a free-running cycle counter captured as ts.

module rm_violation_logger
    import rm_violation_logger_pkg::*;
#(
    parameter int unsigned NUM_LANES  = RM_NUM_LANES,
    parameter int unsigned NUM_RULES  = RM_NUM_RULES,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_LANES*NUM_RULES-1:0] monitor_i,
    input  logic [NUM_LANES-1:0]           lane_reset_i,
    input  logic [RM_VLEN-1:0]             pc_i,
    output logic                           rec_valid_o,
    output rm_viol_rec_t                   rec_o,
    input  logic                           rec_ready_i,
    output logic                           irq_o,
    input  logic                           clear_i,
    output logic [CNT_W-1:0]               overflow_cnt_o
);

    typedef logic [NUM_LANES-1:0][NUM_RULES-1:0] flag_t;

    localparam int unsigned LOST_W = $clog2(NUM_LANES*NUM_RULES + 1);

    flag_t                    mon;
    flag_t                    prev_q;
    flag_t                    pend_q;
    flag_t                    pend_d;
    flag_t                    rise;
    flag_t                    gnt_mask;
    logic [RM_VLEN-1:0]       pc_q [NUM_LANES];
    logic [RM_LANE_IDX_W-1:0] rr_q;
    logic [RM_LANE_IDX_W-1:0] gnt_lane;
    logic [RM_RULE_IDX_W-1:0] gnt_rule;
    logic                     gnt_valid;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic                     may_grant;
    logic [LOST_W-1:0]        lost_cnt;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_base;
    logic [CNT_W:0]           cnt_sum;
    logic                     irq_q;
    rm_viol_rec_t             push_rec;

`ifdef RM_VIOL_TIMESTAMP_EN
    logic [31:0]              cyc_q;
    logic [31:0]              ts_q [NUM_LANES];
`endif

    assign mon = monitor_i;

    // A lane being reset ignores any rise in the same cycle.
    always_comb begin
        rise = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            rise[l] = lane_reset_i[l] ? '0 : (mon[l] & ~prev_q[l]);
        end
    end

    // Round-robin lane scan from rr_q, lowest pending rule within the lane.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_lane  = '0;
        gnt_rule  = '0;
        gnt_mask  = '0;
        fifo_pop  = rec_ready_i & ~fifo_empty;
        may_grant = ~fifo_full | fifo_pop;
        for (int i = 0; i < NUM_LANES; i++) begin
            idx = (int'(rr_q) + i) % int'(NUM_LANES);
            if (may_grant && !gnt_valid && (|pend_q[idx])) begin
                gnt_valid = 1'b1;
                gnt_lane  = RM_LANE_IDX_W'(idx);
                for (int r = NUM_RULES - 1; r >= 0; r--) begin
                    if (pend_q[idx][r]) gnt_rule = RM_RULE_IDX_W'(r);
                end
            end
        end
        if (gnt_valid) gnt_mask[gnt_lane][gnt_rule] = 1'b1;
    end

    // A rise onto a bit that stays pending is counted as lost, not re-queued.
    always_comb begin
        pend_d   = '0;
        lost_cnt = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                pend_d[l][r] = ~lane_reset_i[l] &
                               ((pend_q[l][r] & ~gnt_mask[l][r]) | rise[l][r]);
                lost_cnt = lost_cnt +
                           LOST_W'(rise[l][r] & pend_q[l][r] & ~gnt_mask[l][r]);
            end
        end
    end

    // Clear drops the old count but keeps losses of the same cycle.
    assign cnt_base = clear_i ? '0 : cnt_q;
    assign cnt_sum  = {1'b0, cnt_base} + (CNT_W+1)'(lost_cnt);

    always_comb begin
        push_rec      = '0;
        push_rec.lane = gnt_lane;
        push_rec.rule = gnt_rule;
        push_rec.pc   = pc_q[gnt_lane];
`ifdef RM_VIOL_TIMESTAMP_EN
        push_rec.ts   = ts_q[gnt_lane];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
            pend_q <= '0;
            rr_q   <= '0;
            cnt_q  <= '0;
            irq_q  <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) pc_q[l] <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                prev_q[l] <= lane_reset_i[l] ? '0 : mon[l];
                // Capture pc only when the lane goes from idle to pending.
                if ((pend_q[l] == '0) && (pend_d[l] != '0)) pc_q[l] <= pc_i;
            end
            pend_q <= pend_d;
            if (gnt_valid) begin
                rr_q <= (int'(gnt_lane) == int'(NUM_LANES) - 1) ? '0 : gnt_lane + 1'b1;
            end
            cnt_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            irq_q <= gnt_valid | (irq_q & ~clear_i);
        end
    end

`ifdef RM_VIOL_TIMESTAMP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q <= '0;
            for (int l = 0; l < NUM_LANES; l++) ts_q[l] <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            for (int l = 0; l < NUM_LANES; l++) begin
                if ((pend_q[l] == '0) && (pend_d[l] != '0)) ts_q[l] <= cyc_q;
            end
        end
    end
`endif

    rm_viol_fifo #(
        .T     (rm_viol_rec_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt_valid),
        .data_i  (push_rec),
        .pop_i   (fifo_pop),
        .data_o  (rec_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rec_valid_o    = ~fifo_empty;
    assign irq_o          = irq_q;
    assign overflow_cnt_o = cnt_q;

endmodule

// File: tb/tb_rm_violation_logger.sv
// tb/tb_rm_violation_logger.sv - self-checking bench for rm_violation_logger
`timescale 1ns/1ps

module tb_rm_violation_logger;
    import rm_violation_logger_pkg::*;

    localparam int NL = 4;
    localparam int NR = 5;
    localparam int FD = 8;
    localparam int CW = 4;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic [NL*NR-1:0]      monitor_i;
    logic [NL-1:0]         lane_reset_i;
    logic [RM_VLEN-1:0]    pc_i;
    logic                  rec_valid_o;
    rm_viol_rec_t          rec_o;
    logic                  rec_ready_i;
    logic                  irq_o;
    logic                  clear_i;
    logic [CW-1:0]         overflow_cnt_o;

    int checks   = 0;
    int failures = 0;

    rm_viol_rec_t exp_q[$];
    logic [31:0]  ts_exp_q[$];
    logic [31:0]  cyc;

    typedef struct {
        int          lane;
        int          rule;
        logic [63:0] pc;
        logic [1:0]  exp_lane;
        logic [2:0]  exp_rule;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    // Mirror of a free-running cycle counter, reset with the DUT.
    always @(posedge clk) cyc <= rst_i ? 32'd0 : cyc + 32'd1;

    rm_violation_logger #(
        .NUM_LANES  (NL),
        .NUM_RULES  (NR),
        .FIFO_DEPTH (FD),
        .CNT_W      (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .monitor_i      (monitor_i),
        .lane_reset_i   (lane_reset_i),
        .pc_i           (pc_i),
        .rec_valid_o    (rec_valid_o),
        .rec_o          (rec_o),
        .rec_ready_i    (rec_ready_i),
        .irq_o          (irq_o),
        .clear_i        (clear_i),
        .overflow_cnt_o (overflow_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic rm_viol_rec_t mk(input int lane, input int rule, input logic [63:0] pc);
        rm_viol_rec_t r;
        r      = '0;
        r.lane = RM_LANE_IDX_W'(lane);
        r.rule = RM_RULE_IDX_W'(rule);
        r.pc   = pc;
        return r;
    endfunction

    task automatic expect_rec(input int lane, input int rule, input logic [63:0] pc, input logic [31:0] ts);
        exp_q.push_back(mk(lane, rule, pc));
        ts_exp_q.push_back(ts);
    endtask

    task automatic set_bit(input int lane, input int rule, input logic v);
        monitor_i[lane*NR + rule] = v;
    endtask

    // One-cycle high pulse; ts is the cycle at which the rise is sampled.
    task automatic pulse(input int lane, input int rule, input logic [63:0] pc, output logic [31:0] ts);
        ts = cyc;
        pc_i = pc;
        set_bit(lane, rule, 1'b1);
        tick();
        set_bit(lane, rule, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        monitor_i    = '0;
        lane_reset_i = '0;
        pc_i         = '0;
        rec_ready_i  = 1'b0;
        clear_i      = 1'b0;
        exp_q.delete();
        ts_exp_q.delete();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Pops n records, comparing each against the scoreboard head.
    task automatic drain(input int n, input string name);
        int got;
        int budget;
        got    = 0;
        budget = 200;
        rec_ready_i = 1'b1;
        while (got < n && budget > 0) begin
            if (rec_valid_o) begin
                rm_viol_rec_t e;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_unexpected actual=%0h required=none", name, rec_o);
                end else begin
                    e = exp_q.pop_front();
`ifdef RM_VIOL_TIMESTAMP_EN
                    e.ts = ts_exp_q.pop_front();
`else
                    void'(ts_exp_q.pop_front());
`endif
                    chk({name, "_rec"}, rec_o, e);
                end
                got++;
            end
            tick();
            budget--;
        end
        rec_ready_i = 1'b0;
        if (got < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout popped=%0d required=%0d", name, got, n);
        end
    endtask

    // Fills the FIFO with 8 sequentially granted records.
    task automatic fill();
        logic [31:0] t;
        for (int i = 0; i < FD; i++) begin
            pulse(i % NL, (i + 1) % NR, 64'h1000 + 64'(i), t);
            expect_rec(i % NL, (i + 1) % NR, 64'h1000 + 64'(i), t);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t0;
        logic [31:0] t1;

        vecs[0] = '{0, 0, 64'h0000_0000_0000_0000, 2'd0, 3'd0, 64'h0000_0000_0000_0000};
        vecs[1] = '{3, 4, 64'hFFFF_FFFF_FFFF_FFFC, 2'd3, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[2] = '{1, 2, 64'h0000_0000_8000_0000, 2'd1, 3'd2, 64'h0000_0000_8000_0000};
        vecs[3] = '{2, 0, 64'h0000_0000_0000_1234, 2'd2, 3'd0, 64'h0000_0000_0000_1234};
        vecs[4] = '{0, 4, 64'hDEAD_BEEF_0000_0004, 2'd0, 3'd4, 64'hDEAD_BEEF_0000_0004};
        vecs[5] = '{3, 0, 64'h8000_0000_0000_0000, 2'd3, 3'd0, 64'h8000_0000_0000_0000};

        do_reset();
        chk("reset_valid", rec_valid_o, 0);
        chk("reset_irq", irq_o, 0);
        chk("reset_cnt", overflow_cnt_o, 0);

        // Basic latency: rise sampled at one edge, record visible after the next.
        while (cyc < 5) tick();
        t0 = cyc;
        pc_i = 64'h8000_0010;
        set_bit(2, 3, 1'b1);
        tick();
        chk("t1_valid_n", rec_valid_o, 0);
        tick();
        set_bit(2, 3, 1'b0);
        chk("t1_valid_n1", rec_valid_o, 1);
        chk("t1_lane", rec_o.lane, 2);
        chk("t1_rule", rec_o.rule, 3);
        chk("t1_pc", rec_o.pc, 64'h8000_0010);
        chk("t1_irq", irq_o, 1);
        expect_rec(2, 3, 64'h8000_0010, t0);
        drain(1, "t1");
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t1_irq_clr", irq_o, 0);

        // Table of isolated single rises.
        for (int v = 0; v < 6; v++) begin
            t0 = cyc;
            pc_i = vecs[v].pc;
            set_bit(vecs[v].lane, vecs[v].rule, 1'b1);
            tick();
            set_bit(vecs[v].lane, vecs[v].rule, 1'b0);
            chk($sformatf("vec%0d_lat0", v), rec_valid_o, 0);
            tick();
            chk($sformatf("vec%0d_lat1", v), rec_valid_o, 1);
            chk($sformatf("vec%0d_lane", v), rec_o.lane, vecs[v].exp_lane);
            chk($sformatf("vec%0d_rule", v), rec_o.rule, vecs[v].exp_rule);
            chk($sformatf("vec%0d_pc", v), rec_o.pc, vecs[v].exp_pc);
            expect_rec(vecs[v].exp_lane, vecs[v].exp_rule, vecs[v].exp_pc, t0);
            drain(1, $sformatf("vec%0d", v));
        end

        // Round-robin: lanes 0,1,3 together, then a lone lane-0 rise.
        do_reset();
        tick();
        t0 = cyc;
        pc_i = 64'hA000;
        set_bit(0, 0, 1'b1);
        set_bit(1, 2, 1'b1);
        set_bit(3, 4, 1'b1);
        tick();
        monitor_i = '0;
        tick();
        t1 = cyc;
        pc_i = 64'hB000;
        set_bit(0, 1, 1'b1);
        tick();
        set_bit(0, 1, 1'b0);
        tick();
        tick();
        expect_rec(0, 0, 64'hA000, t0);
        expect_rec(1, 2, 64'hA000, t0);
        expect_rec(3, 4, 64'hA000, t0);
        expect_rec(0, 1, 64'hB000, t1);
        drain(4, "rr");
        chk("rr_empty", exp_q.size(), 0);

        // Full FIFO holds back three rises on lane 2 without loss.
        fill();
        pulse(2, 4, 64'h2000, t0);
        pulse(2, 1, 64'h2001, t1);
        pulse(2, 3, 64'h2002, t1);
        tick();
        tick();
        chk("full_cnt", overflow_cnt_o, 0);
        chk("full_valid", rec_valid_o, 1);
        expect_rec(2, 1, 64'h2000, t0);
        expect_rec(2, 3, 64'h2000, t0);
        expect_rec(2, 4, 64'h2000, t0);
        drain(11, "full");
        chk("full_empty", exp_q.size(), 0);

        // Lost events on a pending bit, clear, and saturation.
        fill();
        pulse(1, 0, 64'h3000, t0);
        pulse(1, 0, 64'h3001, t1);
        pulse(1, 0, 64'h3002, t1);
        chk("ovf_two", overflow_cnt_o, 2);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("ovf_clear", overflow_cnt_o, 0);
        clear_i = 1'b1;
        set_bit(1, 0, 1'b1);
        tick();
        clear_i = 1'b0;
        set_bit(1, 0, 1'b0);
        tick();
        chk("ovf_clear_lost", overflow_cnt_o, 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int i = 0; i < 14; i++) pulse(1, 0, 64'h3003, t1);
        chk("ovf_14", overflow_cnt_o, 14);
        pulse(1, 0, 64'h3003, t1);
        chk("ovf_max", overflow_cnt_o, 15);
        for (int i = 0; i < 6; i++) pulse(1, 0, 64'h3003, t1);
        chk("ovf_sat", overflow_cnt_o, 15);
        expect_rec(1, 0, 64'h3000, t0);
        drain(9, "ovf");
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("ovf_final_clear", overflow_cnt_o, 0);

        // Lane reset drops pending and same-cycle rise, keeps queued records.
        fill();
        pulse(1, 4, 64'h4000, t1);
        lane_reset_i = 4'b0010;
        set_bit(1, 2, 1'b1);
        tick();
        lane_reset_i = '0;
        set_bit(1, 2, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("lrst_cnt", overflow_cnt_o, 0);
        drain(8, "lrst");
        for (int i = 0; i < 4; i++) tick();
        chk("lrst_no_rec", rec_valid_o, 0);

        // Push on the same cycle as clear leaves irq set.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        t0 = cyc;
        pc_i = 64'h5000;
        set_bit(3, 1, 1'b1);
        tick();
        set_bit(3, 1, 1'b0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("irq_push_wins", irq_o, 1);
        expect_rec(3, 1, 64'h5000, t0);
        drain(1, "irq");
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("irq_cleared", irq_o, 0);

`ifdef RM_VIOL_TIMESTAMP_EN
        do_reset();
        while (cyc < 100) tick();
        pc_i = 64'h6000;
        set_bit(0, 0, 1'b1);
        tick();
        set_bit(0, 0, 1'b0);
        tick();
        chk("ts_valid", rec_valid_o, 1);
        chk("ts_100", rec_o.ts, 100);
        expect_rec(0, 0, 64'h6000, 32'd100);
        drain(1, "ts");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
